// File: rtl/rsa_const_gen.sv
// Montgomery pre-computation: Const = 2^(2K) mod M via one shift-and-conditional-subtract per clock.
// Feeds the Const input of the downstream RSA exponentiation unit; done cues the exponentiation start.
module rsa_const_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned K     = WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] Const,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned RW    = WIDTH + 1;
    localparam int unsigned STEPS = 2 * K;
    localparam int unsigned CW    = $clog2(STEPS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] m_lat, m_n;
    logic [RW-1:0]    r, r_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] const_n;
    logic             busy_n, done_n, err_n;
    logic [RW-1:0]    t, t_sub;

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m_lat <= '0;
            r     <= '0;
            cnt   <= '0;
            Const <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            m_lat <= m_n;
            r     <= r_n;
            cnt   <= cnt_n;
            Const <= const_n;
            busy  <= busy_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    // Next-state logic; en low holds everything, including a pending done pulse.
    always_comb begin
        state_n = state;
        m_n     = m_lat;
        r_n     = r;
        cnt_n   = cnt;
        const_n = Const;
        busy_n  = busy;
        done_n  = done;
        err_n   = err;
        t       = r << 1;
        t_sub   = t - {1'b0, m_lat};

        if (en) begin
            done_n = 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (M[0]) begin
                            m_n     = M;
                            r_n     = (M == WIDTH'(1)) ? '0 : RW'(1);
                            cnt_n   = '0;
                            busy_n  = 1'b1;
                            err_n   = 1'b0;
                            state_n = CALC;
                        end else begin
                            const_n = '0;
                            err_n   = 1'b1;
                            done_n  = 1'b1;
                        end
                    end
                end
                CALC: begin
                    // r < M holds, so 2r < 2M and one subtract keeps it reduced.
                    r_n   = (t >= {1'b0, m_lat}) ? t_sub : t;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        const_n = r_n[WIDTH-1:0];
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_const_gen.sv
// Self-checking bench for rsa_const_gen against an arithmetic 2^(2K) mod M reference.
module tb_rsa_const_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned K     = WIDTH + 2;
    localparam int          LAT   = 2 * K;

    logic             clk;
    logic             rst;
    logic             en;
    logic             start;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Const;
    logic             busy;
    logic             done;
    logic             err;

    int errors;
    int checks;

    rsa_const_gen #(.WIDTH(WIDTH), .K(K)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .M     (M),
        .Const (Const),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_const(input int m);
        longint p;
        p = longint'(1) << (2 * K);
        return WIDTH'(p % longint'(m));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with en=1 and wait for done; reports latency and busy-high cycles.
    task automatic do_request(input logic [WIDTH-1:0] m, output int lat, output int busy_cycles);
        start = 1'b1;
        M     = m;
        tick();
        start = 1'b0;
        lat = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) busy_cycles++;
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b0; M = '0;
        tick(); tick();
        checks++;
        if (Const !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset: Const=%0d busy=%b done=%b err=%b, required all zero", Const, busy, done, err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc;
        do_request(8'd251, lat, bc);
        checks++;
        if (lat !== LAT || Const !== 8'd149 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_251: lat=%0d Const=%0d err=%b busy=%b, required lat=%0d Const=149 err=0 busy=0",
                     lat, Const, err, busy, LAT);
        end
        checks++;
        if (bc !== LAT) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d cycles, required %0d", bc, LAT);
        end
        tick();
        checks++;
        if (done !== 1'b0 || Const !== 8'd149) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b Const=%0d, required done=0 Const=149", done, Const);
        end
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] ms   [3] = '{8'd255, 8'd3, 8'd1};
        logic [WIDTH-1:0] want [3] = '{8'd16, 8'd1, 8'd0};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            do_request(ms[i], lat, bc);
            checks++;
            if (lat !== LAT || Const !== want[i] || Const !== ref_const(int'(ms[i])) || err !== 1'b0) begin
                errors++;
                $display("FAIL vector_M%0d: lat=%0d Const=%0d err=%b, required lat=%0d Const=%0d err=0",
                         ms[i], lat, Const, err, LAT, want[i]);
            end
        end
    endtask

    task automatic test_invalid();
        logic [WIDTH-1:0] bad [2] = '{8'd128, 8'd0};
        int lat, bc;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            M     = bad[i];
            tick();
            start = 1'b0;
            checks++;
            if (done !== 1'b1 || err !== 1'b1 || Const !== 8'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL invalid_M%0d: done=%b err=%b Const=%0d busy=%b, required 1 1 0 0",
                         bad[i], done, err, Const, busy);
            end
            tick();
            checks++;
            if (done !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL invalid_after_M%0d: done=%b err=%b busy=%b, required 0 1 0", bad[i], done, err, busy);
            end
        end
        start = 1'b1;
        M     = 8'd251;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL invalid_recover_accept: err=%b busy=%b, required err=0 busy=1", err, busy);
        end
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== LAT || Const !== 8'd149 || err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_recover: lat=%0d Const=%0d err=%b, required lat=%0d Const=149 err=0",
                     lat, Const, err, LAT);
        end
    endtask

    task automatic test_en_gap();
        int lat;
        int pulses;
        start = 1'b1;
        M     = 8'd251;
        tick();
        start = 1'b0;
        lat = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lat++;
        end
        M     = 8'd3;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            lat++;
        end
        en = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== LAT + 5 || done !== 1'b1 || Const !== 8'd149) begin
            errors++;
            $display("FAIL en_gap: lat=%0d done=%b Const=%0d, required lat=%0d done=1 Const=149",
                     lat, done, Const, LAT + 5);
        end
        for (int i = 0; i < 25; i++) begin
            if (done) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_gap_single_done: pulses=%0d busy=%b, required 1 and 0", pulses, busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        start = 1'b1;
        M     = 8'd251;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (Const !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: Const=%0d busy=%b done=%b err=%b, required all zero", Const, busy, done, err);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_done: done=%b at cycle %0d, required 0", done, i);
            end
        end
        do_request(8'd255, lat, bc);
        checks++;
        if (lat !== LAT || Const !== 8'd16) begin
            errors++;
            $display("FAIL reset_mid_after: lat=%0d Const=%0d, required lat=%0d Const=16", lat, Const, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_request(8'd251, lat, bc);
        start = 1'b1;
        M     = 8'd3;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== LAT || Const !== 8'd1) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d Const=%0d, required lat=%0d Const=1", lat, Const, LAT);
        end
    endtask

    task automatic test_done_freeze();
        en = 1'b0;
        tick(); tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_freeze_hold: done=%b, required 1", done);
        end
        en = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_freeze_clear: done=%b, required 0", done);
        end
    endtask

    task automatic test_random();
        int m, en_cnt, guard;
        logic e;
        for (int trial = 0; trial < 200; trial++) begin
            m = int'($urandom_range(0, 127)) * 2 + 1;
            en    = 1'b1;
            start = 1'b1;
            M     = WIDTH'(m);
            tick();
            start = 1'b0;
            M     = WIDTH'($urandom);
            en_cnt = 0;
            guard  = 0;
            while (en_cnt < LAT && guard < 200) begin
                e  = ($urandom_range(0, 3) != 0);
                en = e;
                tick();
                guard++;
                if (e) en_cnt++;
                if (en_cnt < LAT) begin
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL random_early M=%0d step=%0d: done=%b busy=%b, required 0 1",
                                 m, en_cnt, done, busy);
                    end
                end
            end
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || Const !== ref_const(m)) begin
                errors++;
                $display("FAIL random_result M=%0d: done=%b busy=%b err=%b Const=%0d, required 1 0 0 %0d",
                         m, done, busy, err, Const, ref_const(m));
            end
            en = 1'b1;
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; en = 1'b1; start = 1'b0; M = '0;
        test_reset();
        test_basic();
        test_vectors();
        test_invalid();
        test_en_gap();
        test_reset_mid();
        test_back_to_back();
        test_done_freeze();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_const_gen.md
# rsa_const_gen

Montgomery pre-computation stage sitting directly upstream of the RSA exponentiation unit. On a start pulse it computes the Montgomery conversion constant Const = 2^(2·K) mod M, using one shift-and-conditional-subtract step per clock. It holds the result on its output, where it drives the `Const` input of the exponentiation unit. The modulus `M` fed here is the same modulus fed to the exponentiation unit, and `done` is the cue for the controller to start the exponentiation.

## Interface
- WIDTH, 8: operand width; must match the downstream RSA unit.
- K, WIDTH+2: Montgomery radix exponent (radix 2^K); must match the downstream Montgomery multiplier iteration count.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  clock enable; when low, all state, counters and outputs hold.
- start  input  1  single-cycle request; sampled only in IDLE with en=1.
- M  input  WIDTH  modulus; sampled with start, ignored otherwise.
- Const  output  WIDTH  result register, 2^(2K) mod M; holds until the next accepted start completes.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when Const has been updated.
- err  output  1  set with done when M was invalid; cleared on the next accepted start.

## Operation
- States: IDLE, CALC.
- IDLE with en=1 and start=1 accepts a request.
  - Valid M (odd): latch M, set r = (M==1) ? 0 : 1, set step counter = 0, set busy=1, set err=0, go to CALC.
  - Invalid M (zero or even): stay in IDLE, force Const=0, set err=1, pulse done next cycle; busy stays 0.
- CALC, each cycle with en=1:
  - t = 2·r (width WIDTH+1).
  - r = (t >= M) ? t − M : t.
  - Increment counter.
- Invariant r < M; a single conditional subtract suffices.
- Internal r is WIDTH+1 bits and carries no overflow. Const takes r[WIDTH-1:0].
- On the 2K-th step:
  - Write Const = new r.
  - Pulse done.
  - Clear busy.
  - Return to IDLE.
- start while busy=1 is ignored; M changes during CALC have no effect, because the latched copy is used.
- start while done is pulsing (first IDLE cycle) is accepted normally.
- en=0 freezes everything, including a pending done pulse: done remains high until the next en=1 cycle, then clears.
- Reset values: state IDLE, Const=0, busy=0, done=0, err=0, r=0, counter=0.
- rst mid-CALC aborts immediately to these values; no done is issued.
- rst has priority over en and start.

## Timing
- Edge e0 samples start (valid M): busy=1 after e0.
- Steps execute on edges e1..e2K.
- After e2K: Const valid, done=1, busy=0. Latency is 2K cycles from the accepting edge (20 cycles for WIDTH=8).
- With en low for n cycles in CALC, latency extends by exactly n.
- Invalid M: after e0, done=1, err=1, Const=0. The next edge clears done.
- done is high for exactly one enabled cycle; err is sticky until the next accepted start.
- Back-to-back: start asserted in the cycle done=1 is accepted on that edge; the new result follows 2K cycles later.

## Test plan
- WIDTH=8, K=10, M=251, start pulse -> after 20 cycles done=1, Const=149, err=0; busy high for exactly 20 cycles.
- M=255 -> Const=16; then M=3 -> Const=1; then M=1 -> Const=0. All with err=0 and 20-cycle latency each.
- M=128, then M=0 -> done one cycle after start, err=1, Const=0, busy never high. A subsequent M=251 request clears err and yields 149.
- M=251 start, en low for 5 cycles mid-CALC, M input changed to 3 during CALC, second start asserted while busy -> done after 25 cycles, Const=149, only one done pulse.
- rst asserted 7 cycles into CALC -> next cycle Const=0, busy=0, done=0. A later start with M=255 completes normally with Const=16.
- Random odd M in 1..255 (≥200 trials, random en gaps) -> Const equals the reference model 2^20 mod M; done coincides with the model's completion cycle.
